// File: rtl/maq_r.sv
// Countdown timer (MM:SS, BCD) with run/pause control and a timed alarm.
// Counts down on 1 Hz enable ticks; all outputs come straight from registers.
module maq_r #(
    parameter int ALARM_TICKS = 5
) (
    input  logic       maqr_clock,
    input  logic       maqr_reset_n,
    input  logic       maqr_enable,
    input  logic       maqr_load,
    input  logic       maqr_start,
    input  logic       maqr_pause,
    input  logic [2:0] maqr_set_min_msd,
    input  logic [3:0] maqr_set_min_lsd,
    input  logic [2:0] maqr_set_sec_msd,
    input  logic [3:0] maqr_set_sec_lsd,
    output logic [2:0] maqr_min_msd,
    output logic [3:0] maqr_min_lsd,
    output logic [2:0] maqr_sec_msd,
    output logic [3:0] maqr_sec_lsd,
    output logic       maqr_running,
    output logic       maqr_zero,
    output logic       maqr_alarm
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

    localparam logic [7:0] ALARM_LAST = 8'(ALARM_TICKS - 1);

    // Count packing: {min_msd[2:0], min_lsd[3:0], sec_msd[2:0], sec_lsd[3:0]}
    state_t      state_r, state_s;
    logic [13:0] count_r, count_s;
    logic [13:0] load_val_s, dec_val_s;
    logic [7:0]  alarm_cnt_r, alarm_cnt_s;
    logic        zero_r, zero_s;
    logic        running_r, alarm_r;
    logic        count_nz_s;

    function automatic logic [2:0] clamp_msd(input logic [2:0] v);
        return (v > 3'd5) ? 3'd5 : v;
    endfunction

    function automatic logic [3:0] clamp_lsd(input logic [3:0] v);
        return (v > 4'd9) ? 4'd9 : v;
    endfunction

    // Caller guarantees a nonzero count, so the final min_msd borrow cannot wrap.
    function automatic logic [13:0] bcd_dec(input logic [13:0] c);
        logic [2:0] mm;
        logic [3:0] ml;
        logic [2:0] sm;
        logic [3:0] sl;
        {mm, ml, sm, sl} = c;
        if (sl != 4'd0) begin
            sl = sl - 4'd1;
        end else begin
            sl = 4'd9;
            if (sm != 3'd0) begin
                sm = sm - 3'd1;
            end else begin
                sm = 3'd5;
                if (ml != 4'd0) begin
                    ml = ml - 4'd1;
                end else begin
                    ml = 4'd9;
                    mm = mm - 3'd1;
                end
            end
        end
        return {mm, ml, sm, sl};
    endfunction

    assign load_val_s = {clamp_msd(maqr_set_min_msd), clamp_lsd(maqr_set_min_lsd),
                         clamp_msd(maqr_set_sec_msd), clamp_lsd(maqr_set_sec_lsd)};
    assign dec_val_s  = bcd_dec(count_r);
    assign count_nz_s = (count_r != 14'd0);

    // Next-state, next-count and alarm tick logic; load > pause > start.
    always_comb begin
        state_s     = state_r;
        count_s     = count_r;
        alarm_cnt_s = alarm_cnt_r;
        zero_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (maqr_load) begin
                    count_s = load_val_s;
                end else if (maqr_pause) begin
                    state_s = ST_IDLE;
                end else if (maqr_start && count_nz_s) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (maqr_pause) begin
                    state_s = ST_PAUSE;
                end else if (maqr_enable && count_nz_s) begin
                    count_s = dec_val_s;
                    if (dec_val_s == 14'd0) begin
                        state_s     = ST_ALARM;
                        zero_s      = 1'b1;
                        alarm_cnt_s = 8'd0;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (maqr_load) begin
                    state_s = ST_IDLE;
                    count_s = load_val_s;
                end else if (maqr_pause) begin
                    state_s = ST_PAUSE;
                end else if (maqr_start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_PAUSE;
                end
            end
            ST_ALARM: begin
                if (maqr_load) begin
                    state_s     = ST_IDLE;
                    count_s     = load_val_s;
                    alarm_cnt_s = 8'd0;
                end else if (maqr_pause || maqr_start) begin
                    state_s     = ST_IDLE;
                    alarm_cnt_s = 8'd0;
                end else if (maqr_enable) begin
                    if (alarm_cnt_r >= ALARM_LAST) begin
                        state_s     = ST_IDLE;
                        alarm_cnt_s = 8'd0;
                    end else begin
                        alarm_cnt_s = alarm_cnt_r + 8'd1;
                    end
                end else begin
                    state_s = ST_ALARM;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                alarm_cnt_s = 8'd0;
            end
        endcase
    end

    // State, count and registered flag outputs.
    always_ff @(posedge maqr_clock or negedge maqr_reset_n) begin
        if (!maqr_reset_n) begin
            state_r     <= ST_IDLE;
            count_r     <= 14'd0;
            alarm_cnt_r <= 8'd0;
            zero_r      <= 1'b0;
            running_r   <= 1'b0;
            alarm_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            count_r     <= count_s;
            alarm_cnt_r <= alarm_cnt_s;
            zero_r      <= zero_s;
            running_r   <= (state_s == ST_RUN);
            alarm_r     <= (state_s == ST_ALARM);
        end
    end

    assign maqr_min_msd = count_r[13:11];
    assign maqr_min_lsd = count_r[10:7];
    assign maqr_sec_msd = count_r[6:4];
    assign maqr_sec_lsd = count_r[3:0];
    assign maqr_running = running_r;
    assign maqr_zero    = zero_r;
    assign maqr_alarm   = alarm_r;

endmodule

// File: tb/tb_maq_r.sv
// Directed bench for maq_r: load/clamp, BCD borrow, pause, alarm and async reset.
module tb_maq_r;
    logic       clk;
    logic       rst_n;
    logic       enable, load, start, pause;
    logic [2:0] set_min_msd, set_sec_msd;
    logic [3:0] set_min_lsd, set_sec_lsd;
    logic [2:0] min_msd, sec_msd;
    logic [3:0] min_lsd, sec_lsd;
    logic       running, zero, alarm;

    int checks   = 0;
    int failures = 0;
    int zero_seen = 0;

    logic [15:0] cnt;
    assign cnt = {1'b0, min_msd, min_lsd, 1'b0, sec_msd, sec_lsd};

    maq_r #(.ALARM_TICKS(5)) dut (
        .maqr_clock(clk), .maqr_reset_n(rst_n), .maqr_enable(enable),
        .maqr_load(load), .maqr_start(start), .maqr_pause(pause),
        .maqr_set_min_msd(set_min_msd), .maqr_set_min_lsd(set_min_lsd),
        .maqr_set_sec_msd(set_sec_msd), .maqr_set_sec_lsd(set_sec_lsd),
        .maqr_min_msd(min_msd), .maqr_min_lsd(min_lsd),
        .maqr_sec_msd(sec_msd), .maqr_sec_lsd(sec_lsd),
        .maqr_running(running), .maqr_zero(zero), .maqr_alarm(alarm)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // One clock with the given commands; inputs change 1 ns after the edge.
    task automatic cyc(input logic en, input logic ld, input logic st, input logic ps);
        enable = en; load = ld; start = st; pause = ps;
        @(posedge clk); #1;
        enable = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
        if (zero === 1'b1) zero_seen++;
    endtask

    task automatic set_preset(input logic [2:0] mm, input logic [3:0] ml,
                              input logic [2:0] sm, input logic [3:0] sl);
        set_min_msd = mm; set_min_lsd = ml; set_sec_msd = sm; set_sec_lsd = sl;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({cnt, running, zero, alarm} !== {16'h0000, 3'b000}) begin
            failures++;
            $display("FAIL reset_state got=%h/%b%b%b exp=0000/000", cnt, running, zero, alarm);
        end
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_clamp();
        set_preset(3'd7, 4'd12, 3'd6, 4'd15);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (cnt !== 16'h5959) begin
            failures++; $display("FAIL clamp_load got=%h exp=5959", cnt);
        end
    endtask

    task automatic test_zero_start();
        set_preset(3'd0, 4'd0, 3'd0, 4'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        zero_seen = 0;
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({cnt, running, alarm} !== {16'h0000, 2'b00} || zero_seen !== 0) begin
            failures++;
            $display("FAIL start_at_zero got=%h run=%b alarm=%b zeros=%0d exp=0000/0/0/0",
                     cnt, running, alarm, zero_seen);
        end
    endtask

    task automatic test_borrow();
        set_preset(3'd1, 4'd0, 3'd0, 4'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (running !== 1'b1) begin
            failures++; $display("FAIL borrow_start running=%b exp=1", running);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (cnt !== 16'h0959) begin
            failures++; $display("FAIL borrow_tick1 got=%h exp=0959", cnt);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (cnt !== 16'h0958) begin
            failures++; $display("FAIL borrow_tick2 got=%h exp=0958", cnt);
        end
        set_preset(3'd2, 4'd2, 3'd2, 4'd2);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (cnt !== 16'h0958 || running !== 1'b1) begin
            failures++; $display("FAIL load_in_run got=%h run=%b exp=0958/1", cnt, running);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_pause_enable();
        set_preset(3'd0, 4'd0, 3'd3, 4'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (cnt !== 16'h0030 || running !== 1'b0 || alarm !== 1'b0) begin
            failures++;
            $display("FAIL pause_with_tick got=%h run=%b exp=0030/0", cnt, running);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (cnt !== 16'h0030) begin
            failures++; $display("FAIL tick_in_pause got=%h exp=0030", cnt);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (cnt !== 16'h0029 || running !== 1'b1) begin
            failures++; $display("FAIL resume_tick got=%h run=%b exp=0029/1", cnt, running);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        // load and start together in PAUSE: load wins, stays idle
        set_preset(3'd0, 4'd4, 3'd0, 4'd4);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (cnt !== 16'h0404 || running !== 1'b0) begin
            failures++; $display("FAIL load_over_start got=%h run=%b exp=0404/0", cnt, running);
        end
    endtask

    task automatic test_full_countdown();
        set_preset(3'd0, 4'd1, 3'd0, 4'd5);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        zero_seen = 0;
        for (int t = 1; t <= 65; t++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            if (t == 5) begin
                checks++;
                if (cnt !== 16'h0100) begin
                    failures++; $display("FAIL cd_tick5 got=%h exp=0100", cnt);
                end
            end else if (t == 6) begin
                checks++;
                if (cnt !== 16'h0059) begin
                    failures++; $display("FAIL cd_tick6 got=%h exp=0059", cnt);
                end
            end else if (t == 64) begin
                checks++;
                if (cnt !== 16'h0001 || zero !== 1'b0 || alarm !== 1'b0 || running !== 1'b1) begin
                    failures++; $display("FAIL cd_tick64 got=%h z=%b a=%b r=%b exp=0001/0/0/1",
                                         cnt, zero, alarm, running);
                end
            end else if (t == 65) begin
                checks++;
                if (cnt !== 16'h0000 || zero !== 1'b1 || alarm !== 1'b1 || running !== 1'b0) begin
                    failures++; $display("FAIL cd_tick65 got=%h z=%b a=%b r=%b exp=0000/1/1/0",
                                         cnt, zero, alarm, running);
                end
            end
            if (t != 65) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (zero !== 1'b0 || alarm !== 1'b1) begin
            failures++; $display("FAIL zero_one_clock z=%b a=%b exp=0/1", zero, alarm);
        end
        for (int a = 1; a <= 5; a++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            checks++;
            if (alarm !== (a < 5)) begin
                failures++; $display("FAIL alarm_tick%0d alarm=%b exp=%b", a, alarm, (a < 5));
            end
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
        end
        checks++;
        if (zero_seen !== 1 || cnt !== 16'h0000) begin
            failures++; $display("FAIL zero_pulses got=%0d cnt=%h exp=1/0000", zero_seen, cnt);
        end
    endtask

    task automatic test_alarm_ack();
        set_preset(3'd0, 4'd0, 3'd0, 4'd2);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (alarm !== 1'b1) begin
            failures++; $display("FAIL ack_enter alarm=%b exp=1", alarm);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (alarm !== 1'b0 || running !== 1'b0 || cnt !== 16'h0000) begin
            failures++; $display("FAIL ack_pause alarm=%b run=%b cnt=%h exp=0/0/0000",
                                 alarm, running, cnt);
        end
    endtask

    task automatic test_async_reset();
        set_preset(3'd0, 4'd0, 3'd1, 4'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        #4;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cnt, running, zero, alarm} !== {16'h0000, 3'b000}) begin
            failures++;
            $display("FAIL async_reset got=%h/%b%b%b exp=0000/000", cnt, running, zero, alarm);
        end
        @(posedge clk); #5;
        rst_n = 1'b1;
        @(posedge clk); #1;
        set_preset(3'd0, 4'd0, 3'd0, 4'd3);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (cnt !== 16'h0003 || running !== 1'b1) begin
            failures++; $display("FAIL post_reset got=%h run=%b exp=0003/1", cnt, running);
        end
    endtask

    initial begin
        enable = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
        set_preset(3'd0, 4'd0, 3'd0, 4'd0);
        test_reset();
        test_clamp();
        test_zero_start();
        test_borrow();
        test_pause_enable();
        test_full_countdown();
        test_alarm_ack();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/maq_r.md
MAQ_R -- requirements
Module: maq_r

Interface
REQ-001 SHALL have parameter ALARM_TICKS, default 5: number of maqr_enable ticks for which maqr_alarm stays high (range 1..255).
REQ-002 SHALL have port maqr_clock  input  1  system clock, 50 MHz; all state changes on its rising edge.
REQ-003 SHALL have port maqr_reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port maqr_enable  input  1  1 Hz tick, high for one clock.
REQ-005 SHALL have port maqr_load  input  1  load the preset value from the maqr_set_* ports.
REQ-006 SHALL have port maqr_start  input  1  start or resume the countdown.
REQ-007 SHALL have port maqr_pause  input  1  pause the countdown, or acknowledge the alarm.
REQ-008 SHALL have ports maqr_set_min_msd / maqr_set_sec_msd  input  3 each  preset tens digits (BCD).
REQ-009 SHALL have ports maqr_set_min_lsd / maqr_set_sec_lsd  input  4 each  preset units digits (BCD).
REQ-010 SHALL have ports maqr_min_msd / maqr_sec_msd  output  3 each  current tens digits (BCD).
REQ-011 SHALL have ports maqr_min_lsd / maqr_sec_lsd  output  4 each  current units digits (BCD).
REQ-012 SHALL have port maqr_running  output  1  high while the state is RUN.
REQ-013 SHALL have port maqr_zero  output  1  one-clock pulse when the count reaches 00:00.
REQ-014 SHALL have port maqr_alarm  output  1  high while the state is ALARM.

Function
REQ-015 SHALL implement states IDLE, RUN, PAUSE and ALARM; all outputs SHALL be registered.
REQ-016 SHALL apply command priority load > pause > start when commands coincide in one cycle.
REQ-017 SHALL accept load in IDLE, PAUSE and ALARM; state becomes IDLE; load SHALL be ignored in RUN.
REQ-018 SHALL clamp preset digits on load:
- any msd value > 5 loads as 5
- any lsd value > 9 loads as 9
REQ-019 SHALL handle start as follows:
- IDLE with a nonzero count -> RUN on the next edge
- IDLE with count 00:00 -> start ignored
- PAUSE -> RUN
REQ-020 SHALL move RUN -> PAUSE on pause; a maqr_enable in that same cycle SHALL NOT decrement.
REQ-021 SHALL decrement the count by one second on each maqr_enable in RUN, using BCD borrow:
- sec_lsd 0 -> 9, borrow to sec_msd
- sec_msd 0 -> 5, borrow to min_lsd
- min_lsd 0 -> 9, borrow to min_msd
REQ-022 SHALL, on the tick whose decrement yields 00:00, on the same edge:
- set maqr_zero high for exactly one clock
- enter ALARM with maqr_alarm high
REQ-023 SHALL never underflow; the count SHALL NOT change in IDLE, PAUSE or ALARM except by load or reset.
REQ-024 SHALL, in ALARM, count maqr_enable ticks, then:
- after ALARM_TICKS ticks -> IDLE, maqr_alarm low
- start or pause -> IDLE on the next edge (acknowledge)
REQ-025 SHALL ignore maqr_enable in IDLE and PAUSE.
REQ-026 SHALL hold maqr_running high exactly while in RUN, updated on the same edge as the state change.

Reset
REQ-027 SHALL, while maqr_reset_n is low, asynchronously force:
- all count digits to 0
- state IDLE
- maqr_running, maqr_zero and maqr_alarm to 0
- the alarm tick counter to 0
This applies from any state, including mid-RUN.
REQ-028 SHALL exit reset synchronously, with the first state change on the first rising edge after maqr_reset_n goes high.

Verification
REQ-029 SHALL cover: load 01:05, start, 65 enable ticks -> count 00:00 after tick 65, one maqr_zero pulse, maqr_alarm high for 5 ticks, then IDLE.
REQ-030 SHALL cover: load 10:00, start, 1 tick -> 09:59; then 1 tick -> 09:58.
REQ-031 SHALL cover: in RUN at 00:30, pause and enable in the same cycle -> count holds 00:30 and state is PAUSE; then start plus 1 tick -> 00:29.
REQ-032 SHALL cover: start with count 00:00 -> state stays IDLE, maqr_running = 0, no maqr_zero pulse.
REQ-033 SHALL cover: load with set_min_msd = 7, set_min_lsd = 12, set_sec_msd = 6, set_sec_lsd = 15 -> count 59:59.
REQ-034 SHALL cover: in RUN at 00:10, assert maqr_reset_n low between clock edges -> outputs 00:00, IDLE and all flags 0 immediately, without waiting for a clock edge.
